// File: rtl/dma_pkg.sv
// Shared types and address-map rules for the DMA copy master.
package dma_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // Transfer sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_t;

  // Address map: ROM below RAM_BASE, RAM, output ports, then input ports
  localparam logic [ADDR_W-1:0] RAM_BASE    = 8'h80;
  localparam logic [ADDR_W-1:0] IO_OUT_BASE = 8'hE0;
  localparam logic [ADDR_W-1:0] IO_IN_BASE  = 8'hF0;

  // Memory-side bus payload driven by the master
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } dma_bus_t;

  // Only RAM and output ports accept writes
  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    logic in_ram;
    logic in_out;
    in_ram = (addr >= RAM_BASE) && (addr < IO_OUT_BASE);
    in_out = (addr >= IO_OUT_BASE) && (addr < IO_IN_BASE);
    return in_ram || in_out;
  endfunction

endpackage

// File: rtl/dma_addr_counter.sv
// Loadable 8-bit address up-counter with increment enable; wraps modulo 256.
module dma_addr_counter
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  // Load has priority over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dma_copy_master.sv
// Block-copy bus master: reads a byte, writes it to the destination, repeats.
// Writes to ROM or input ports are suppressed and flagged on a sticky error.
// Optional fill mode (single-cycle writes of a constant) under `DMA_FILL_EN.
module dma_copy_master
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  dma_state_t        state_q, state_d;
  dma_bus_t          bus_q, bus_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;

  logic              addr_load;
  logic              src_inc;
  logic              dst_inc;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;

`ifdef DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_value_q;
  logic [ADDR_W-1:0] dst_step;

  assign dst_step = dst_q + ADDR_W'(1);
`endif

  // Source and destination address counters
  dma_addr_counter u_src_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (addr_load),
    .load_value (src_addr),
    .inc        (src_inc),
    .count      (src_q)
  );

  dma_addr_counter u_dst_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (addr_load),
    .load_value (dst_addr),
    .inc        (dst_inc),
    .count      (dst_q)
  );

  // Next state and next registered outputs; bus is idle unless set below
  always_comb begin
    state_d     = state_q;
    bus_d       = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    remaining_d = remaining_q;
    addr_load   = 1'b0;
    src_inc     = 1'b0;
    dst_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_load   = 1'b1;
          remaining_d = length;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          if (length == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
`ifdef DMA_FILL_EN
          end else if (fill) begin
            state_d       = ST_WR;
            bus_d.address = dst_addr;
            bus_d.write   = is_writable(dst_addr);
            bus_d.wdata   = fill_value;
            error_d       = !is_writable(dst_addr);
`endif
          end else begin
            state_d       = ST_RD;
            bus_d.address = src_addr;
          end
        end
      end

      ST_RD: begin
        state_d       = ST_WAIT;
        busy_d        = 1'b1;
        bus_d.address = src_q;
      end

      // rdata is valid now; it goes straight into the wdata register
      ST_WAIT: begin
        state_d       = ST_WR;
        busy_d        = 1'b1;
        src_inc       = 1'b1;
        bus_d.address = dst_q;
        bus_d.write   = is_writable(dst_q);
        bus_d.wdata   = rdata;
        if (!is_writable(dst_q)) begin
          error_d = 1'b1;
        end
      end

      ST_WR: begin
        busy_d      = 1'b1;
        dst_inc     = 1'b1;
        remaining_d = remaining_q - ADDR_W'(1);
        if (remaining_q == ADDR_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
`ifdef DMA_FILL_EN
        end else if (fill_q) begin
          state_d       = ST_WR;
          bus_d.address = dst_step;
          bus_d.write   = is_writable(dst_step);
          bus_d.wdata   = fill_value_q;
          if (!is_writable(dst_step)) begin
            error_d = 1'b1;
          end
`endif
        end else begin
          state_d       = ST_RD;
          bus_d.address = src_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef DMA_FILL_EN
  // Fill configuration captured on an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q       <= 1'b0;
      fill_value_q <= '0;
    end else if (addr_load) begin
      fill_q       <= fill;
      fill_value_q <= fill_value;
    end
  end
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign address = bus_q.address;
  assign write   = bus_q.write;
  assign wdata   = bus_q.wdata;

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed self-checking bench for dma_copy_master with a behavioural memory.
module tb_dma_copy_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr, dst_addr, length;
  logic       busy, done, error;
  logic [7:0] address;
  logic       write;
  logic [7:0] wdata;
  logic [7:0] rdata;
`ifdef DMA_FILL_EN
  logic       fill;
  logic [7:0] fill_value;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dma_copy_master dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
`ifdef DMA_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .busy       (busy),
    .done       (done),
    .error      (error),
    .address    (address),
    .write      (write),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  // Memory model: registered read, writes only to RAM/output ports, backdoor preload
  logic [7:0] mem [0:255];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;
  int wr_count = 0;
  int done_count = 0;
  int bad_wr_count = 0;

  always @(posedge clk) begin
    rdata <= mem[address];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (write && address >= 8'h80 && address < 8'hF0) mem[address] <= wdata;
    if (write) wr_count <= wr_count + 1;
    if (write && !(address >= 8'h80 && address < 8'hF0)) bad_wr_count <= bad_wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  // Present a one-cycle start from IDLE; afterwards cyc=1 is the first cycle after sampling
  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(output int at);
    while (!done && cyc < 200) step();
    at = done ? cyc : -1;
  endtask

  int at, w0, d0;

  initial begin
    reset = 1'b1; start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    src_addr = '0; dst_addr = '0; length = '0;
`ifdef DMA_FILL_EN
    fill = 1'b0; fill_value = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_address", address, 8'h00);
    check("rst_write", write, 1'b0);
    check("rst_wdata", wdata, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    poke(8'h80, 8'h11); poke(8'h81, 8'h22); poke(8'h82, 8'h33); poke(8'h83, 8'h44);
    for (int i = 0; i < 4; i++) poke(8'(8'h90 + i), 8'h00);

    // Copy to RAM
    w0 = wr_count;
    launch(8'h80, 8'h90, 8'd4);
    check("t1_busy", busy, 1'b1);
    check("t1_rd_addr", address, 8'h80);
    wait_done(at);
    check("t1_done_at", at, 13);
    check("t1_error", error, 1'b0);
    check("t1_writes", wr_count - w0, 4);
    check("t1_mem90", mem[8'h90], 8'h11);
    check("t1_mem91", mem[8'h91], 8'h22);
    check("t1_mem92", mem[8'h92], 8'h33);
    check("t1_mem93", mem[8'h93], 8'h44);
    step();
    check("t1_done_pulse", done, 1'b0);
    check("t1_busy_end", busy, 1'b0);

    // Copy input port to output port
    poke(8'hF0, 8'hF1); poke(8'hE0, 8'h00);
    w0 = wr_count;
    launch(8'hF0, 8'hE0, 8'd1);
    wait_done(at);
    check("t2_done_at", at, 4);
    check("t2_writes", wr_count - w0, 1);
    check("t2_port_out", mem[8'hE0], 8'hF1);

    // Reset in the WR cycle of byte 2
    poke(8'hA8, 8'h5A); poke(8'hA9, 8'h5A);
    w0 = wr_count; d0 = done_count;
    launch(8'h80, 8'hA8, 8'd3);
    while (cyc < 6) step();
    check("t4_wr2_write", write, 1'b1);
    check("t4_wr2_addr", address, 8'hA9);
    check("t4_wr2_wdata", wdata, 8'h22);
    reset = 1'b1;
    #1;
    check("t4_rst_write", write, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_address", address, 8'h00);
    check("t4_rst_wdata", wdata, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step();
    check("t4_memA8", mem[8'hA8], 8'h11);
    check("t4_memA9", mem[8'hA9], 8'h5A);
    check("t4_writes", wr_count - w0, 1);
    check("t4_no_done", done_count - d0, 0);

    // Start while busy is ignored
    poke(8'hC0, 8'h00); poke(8'hC1, 8'h00); poke(8'hC8, 8'h00);
    w0 = wr_count; d0 = done_count;
    launch(8'h80, 8'hC0, 8'd2);
    step();
    src_addr = 8'h82; dst_addr = 8'hC8; length = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(at);
    check("t5_done_at", at, 7);
    repeat (20) step();
    check("t5_writes", wr_count - w0, 2);
    check("t5_dones", done_count - d0, 1);
    check("t5_memC0", mem[8'hC0], 8'h11);
    check("t5_memC1", mem[8'hC1], 8'h22);
    check("t5_memC8", mem[8'hC8], 8'h00);

    // Protected destination 0x7F, second byte lands in 0x80
    w0 = wr_count;
    launch(8'h80, 8'h7F, 8'd2);
    step(); step();
    check("t3_wr1_addr", address, 8'h7F);
    check("t3_wr1_write", write, 1'b0);
    check("t3_wr1_error", error, 1'b1);
    wait_done(at);
    check("t3_done_at", at, 7);
    repeat (3) step();
    check("t3_error_sticky", error, 1'b1);
    check("t3_writes", wr_count - w0, 1);
    check("t3_mem80", mem[8'h80], 8'h22);

    // Destination wraps 0xFF -> 0x00, both protected
    w0 = wr_count;
    launch(8'hDF, 8'hFF, 8'd2);
    check("tw_error_clr", error, 1'b0);
    while (cyc < 6) step();
    check("tw_wrap_addr", address, 8'h00);
    check("tw_wrap_write", write, 1'b0);
    wait_done(at);
    check("tw_done_at", at, 7);
    check("tw_writes", wr_count - w0, 0);
    check("tw_error", error, 1'b1);

    // Zero length
    w0 = wr_count;
    launch(8'h80, 8'h90, 8'd0);
    check("tz_done", done, 1'b1);
    check("tz_busy", busy, 1'b1);
    check("tz_address", address, 8'h00);
    check("tz_error_clr", error, 1'b0);
    repeat (3) step();
    check("tz_writes", wr_count - w0, 0);

`ifdef DMA_FILL_EN
    // Fill mode
    w0 = wr_count;
    fill = 1'b1; fill_value = 8'hA5;
    launch(8'h00, 8'hA0, 8'd3);
    fill = 1'b0;
    wait_done(at);
    check("tf_done_at", at, 4);
    check("tf_writes", wr_count - w0, 3);
    check("tf_memA0", mem[8'hA0], 8'hA5);
    check("tf_memA1", mem[8'hA1], 8'hA5);
    check("tf_memA2", mem[8'hA2], 8'hA5);
`endif

    check("bad_writes", bad_wr_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
